// File: rtl/prbs_pkg.sv
// Mode encodings and per-polynomial ORDER/TAP lookups shared by the PRBS generator.
package prbs_pkg;

    localparam int MAX_ORDER = 31;

    typedef enum logic [2:0] {
        MODE_PRBS7  = 3'd0,
        MODE_PRBS9  = 3'd1,
        MODE_PRBS15 = 3'd2,
        MODE_PRBS23 = 3'd3,
        MODE_PRBS31 = 3'd4
    } prbs_mode_e;

    // Encodings 5-7 fold onto PRBS7.
    function automatic prbs_mode_e norm_mode(input logic [2:0] m);
        prbs_mode_e r;
        case (m)
            MODE_PRBS9:  r = MODE_PRBS9;
            MODE_PRBS15: r = MODE_PRBS15;
            MODE_PRBS23: r = MODE_PRBS23;
            MODE_PRBS31: r = MODE_PRBS31;
            default:     r = MODE_PRBS7;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] mode_order(input prbs_mode_e m);
        logic [4:0] r;
        case (m)
            MODE_PRBS9:  r = 5'd9;
            MODE_PRBS15: r = 5'd15;
            MODE_PRBS23: r = 5'd23;
            MODE_PRBS31: r = 5'd31;
            default:     r = 5'd7;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] mode_tap(input prbs_mode_e m);
        logic [4:0] r;
        case (m)
            MODE_PRBS9:  r = 5'd5;
            MODE_PRBS15: r = 5'd14;
            MODE_PRBS23: r = 5'd18;
            MODE_PRBS31: r = 5'd28;
            default:     r = 5'd6;
        endcase
        return r;
    endfunction

    function automatic logic [MAX_ORDER-1:0] live_mask(input prbs_mode_e m);
        return {MAX_ORDER{1'b1}} >> (5'd31 - mode_order(m));
    endfunction

endpackage

// File: rtl/prbs_gen_par_if.sv
// Output beat stream of the parallel PRBS generator, plus its accepted-beat counter.
interface prbs_gen_par_if #(
    parameter int DATA_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       beat_cnt;

    modport master (output out_valid, output out_data, output beat_cnt, input out_ready);
    modport slave  (input out_valid, input out_data, input beat_cnt, output out_ready);
endinterface

// File: rtl/prbs_step_unroll.sv
// Advances the LFSR DATA_W serial steps in one cycle; bits_o[0] is the earliest bit shifted out.
module prbs_step_unroll
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [MAX_ORDER-1:0] state_i,
    input  prbs_mode_e           mode_i,
    output logic [MAX_ORDER-1:0] state_o,
    output logic [DATA_W-1:0]    bits_o
);
    logic [4:0]           order;
    logic [4:0]           tap;
    logic [MAX_ORDER-1:0] mask;
    logic [MAX_ORDER-1:0] s;

    assign order = mode_order(mode_i);
    assign tap   = mode_tap(mode_i);
    assign mask  = live_mask(mode_i);

    // Masking after each shift keeps the bits above ORDER at zero.
    always_comb begin
        s      = state_i;
        bits_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            bits_o[i] = s[order - 5'd1];
            s = ((s << 1) | {{(MAX_ORDER-1){1'b0}}, s[order - 5'd1] ^ s[tap - 5'd1]}) & mask;
        end
        state_o = s;
    end

endmodule

// File: rtl/prbs_gen_par.sv
// Parallel PRBS generator with valid/ready output, runtime polynomial select and seed load.
// Define PRBS_ERR_INJ_EN to add the err_inj port that inverts bit 0 of the next loaded beat.
module prbs_gen_par
    import prbs_pkg::*;
#(
    parameter int         DATA_W       = 8,
    parameter logic [2:0] DEFAULT_MODE = 3'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [2:0]           mode_i,
    input  logic                 seed_load,
    input  logic [MAX_ORDER-1:0] seed_i,
`ifdef PRBS_ERR_INJ_EN
    input  logic                 err_inj,
`endif
    prbs_gen_par_if.master       bus
);
    prbs_mode_e           mode_q, mode_d;
    logic [MAX_ORDER-1:0] lfsr_q, lfsr_d;
    logic                 valid_q, valid_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [15:0]          cnt_q, cnt_d;

    prbs_mode_e           new_mode;
    logic [MAX_ORDER-1:0] seed_masked;
    logic [MAX_ORDER-1:0] step_state;
    logic [DATA_W-1:0]    step_bits;
    logic                 accept;
    logic                 advance;
    logic                 inj_flip;

    prbs_step_unroll #(.DATA_W(DATA_W)) u_step (
        .state_i (lfsr_q),
        .mode_i  (mode_q),
        .state_o (step_state),
        .bits_o  (step_bits)
    );

    assign new_mode    = norm_mode(mode_i);
    assign seed_masked = seed_i & live_mask(new_mode);
    assign accept      = valid_q && bus.out_ready;
    assign advance     = !seed_load && en && (!valid_q || bus.out_ready);

    always_comb begin
        mode_d  = mode_q;
        lfsr_d  = lfsr_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = accept ? cnt_q + 16'd1 : cnt_q;
        if (seed_load) begin
            mode_d  = new_mode;
            lfsr_d  = (seed_masked == '0) ? live_mask(new_mode) : seed_masked;
            valid_d = 1'b0;
        end else begin
            if (!valid_q || bus.out_ready) valid_d = en;
            if (advance) begin
                lfsr_d    = step_state;
                data_d    = step_bits;
                data_d[0] = step_bits[0] ^ inj_flip;
            end
            // An all-zero live state would lock up; recover to all ones.
            if ((lfsr_q & live_mask(mode_q)) == '0) lfsr_d = live_mask(mode_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= norm_mode(DEFAULT_MODE);
            lfsr_q  <= live_mask(norm_mode(DEFAULT_MODE));
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PRBS_ERR_INJ_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (advance) err_d = 1'b0;
        if (err_inj) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign inj_flip = err_q;
`else
    assign inj_flip = 1'b0;
`endif

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.beat_cnt  = cnt_q;

endmodule

// File: tb/tb_prbs_gen_par.sv
// Bench for prbs_gen_par: random stimulus against a bit-recurrence PRBS model.
module tb_prbs_gen_par;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [2:0]  mode_i;
    logic        seed_load;
    logic [30:0] seed_i;
`ifdef PRBS_ERR_INJ_EN
    logic        err_inj;
`endif

    prbs_gen_par_if #(.DATA_W(8)) bus ();

    prbs_gen_par #(.DATA_W(8), .DEFAULT_MODE(3'd0)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode_i    (mode_i),
        .seed_load (seed_load),
        .seed_i    (seed_i),
`ifdef PRBS_ERR_INJ_EN
        .err_inj   (err_inj),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: sequence obeys b[n] = b[n-ORDER] ^ b[n-TAP]; win holds the next ORDER bits.
    int         ord_tab[5] = '{7, 9, 15, 23, 31};
    int         tap_tab[5] = '{6, 5, 14, 18, 28};
    int         m_order;
    int         m_tap;
    bit         win[$];
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [15:0] exp_cnt;
    bit         inj_armed;
    logic [7:0] first_beat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_seed(input logic [2:0] m, input logic [30:0] s);
        int sel;
        logic [30:0] full;
        logic [30:0] v;
        sel     = (m > 3'd4) ? 0 : int'(m);
        m_order = ord_tab[sel];
        m_tap   = tap_tab[sel];
        full    = (31'd1 << m_order) - 31'd1;
        v       = s & full;
        if (v == 31'd0) v = full;
        win.delete();
        for (int j = 0; j < m_order; j++) win.push_back(v[m_order-1-j]);
    endtask

    task automatic model_beat(output logic [7:0] beat);
        bit nb;
        for (int i = 0; i < 8; i++) begin
            beat[i] = win[0];
            nb = win[0] ^ win[m_order - m_tap];
            void'(win.pop_front());
            win.push_back(nb);
        end
    endtask

    task automatic model_reset();
        model_seed(3'd0, 31'd0);
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        exp_cnt   = 16'd0;
        inj_armed = 1'b0;
    endtask

    // Called at a negedge with inputs set; applies one clock and checks the outputs.
    task automatic tick();
        if (exp_valid && bus.out_ready) exp_cnt++;
        if (seed_load) begin
            model_seed(mode_i, seed_i);
            exp_valid = 1'b0;
        end else if (!exp_valid || bus.out_ready) begin
            if (en) begin
                model_beat(exp_data);
                if (inj_armed) begin
                    exp_data[0] = ~exp_data[0];
                    inj_armed   = 1'b0;
                end
            end
            exp_valid = en;
        end
`ifdef PRBS_ERR_INJ_EN
        if (err_inj) inj_armed = 1'b1;
`endif
        @(posedge clk);
        @(negedge clk);
        chk("valid", bus.out_valid, exp_valid);
        chk("beat_cnt", bus.beat_cnt, exp_cnt);
        if (exp_valid) chk("data", bus.out_data, exp_data);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode_i = 3'd0; seed_load = 1'b0; seed_i = 31'd0;
        bus.out_ready = 1'b0;
`ifdef PRBS_ERR_INJ_EN
        err_inj = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data", bus.out_data, 8'h00);
        chk("rst_cnt", bus.beat_cnt, 16'd0);
        reset = 1'b0;
        tick();
        tick();

        // First beat one cycle after en, then PRBS7 period check
        en = 1'b1; bus.out_ready = 1'b1;
        tick();
        chk("first_beat", bus.out_data, 8'h7F);
        first_beat = exp_data;
        for (int k = 0; k < 127; k++) begin
            tick();
            chk("nonzero", bus.out_data == 8'h00, 1'b0);
        end
        chk("period_wrap", bus.out_data, first_beat);
        chk("cnt127", bus.beat_cnt, 16'd127);

        // Back-pressure hold for 5 cycles
        bus.out_ready = 1'b0;
        repeat (5) tick();
        bus.out_ready = 1'b1;
        repeat (10) tick();

        // Randomized en/ready/seed_load traffic across all modes
        for (int c = 0; c < 600; c++) begin
            seed_load     = ($urandom_range(0, 39) == 0);
            mode_i        = 3'($urandom_range(0, 7));
            seed_i        = ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom);
            en            = ($urandom_range(0, 7) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (c % 100 == 50) begin
                seed_load = 1'b0; en = 1'b1; bus.out_ready = 1'b0;
                repeat (5) tick();
            end
        end

        // Zero seed on PRBS31 must behave as the all-ones seed
        seed_load = 1'b1; mode_i = 3'd4; seed_i = 31'd0; en = 1'b1; bus.out_ready = 1'b1;
        tick();
        chk("seed_valid_low", bus.out_valid, 1'b0);
        seed_load = 1'b0; mode_i = 3'd0;
        tick();
        chk("prbs31_first", bus.out_data, 8'hFF);
        repeat (40) tick();

        // Asynchronous reset mid-stream
        reset = 1'b1;
        #1;
        chk("async_valid", bus.out_valid, 1'b0);
        chk("async_cnt", bus.beat_cnt, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick();
        chk("restart_beat", bus.out_data, 8'h7F);
        repeat (20) tick();

`ifdef PRBS_ERR_INJ_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        model_reset();
        err_inj = 1'b1;
        tick();
        err_inj = 1'b0; en = 1'b1;
        tick();
        chk("inj_beat", bus.out_data, 8'h7E);
        repeat (20) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
